// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared definitions for the CPU memory-side arbiter.
//   arb_state_t : bus sequencing state (one outstanding transaction at most)
//   chan_t      : which core port owns the bus transaction being set up
package cpu_mem_arbiter_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ_I  = 3'd1,
        REQ_D  = 3'd2,
        WAIT_I = 3'd3,
        WAIT_D = 3'd4
    } arb_state_t;

    typedef enum logic {
        CH_I = 1'b0,
        CH_D = 1'b1
    } chan_t;

endpackage

// File: rtl/cpu_mem_arbiter_mem_req_mux.sv
// Bus request field selector.
// Picks address, byte enables and write data for the channel about to be
// issued; the result feeds the registered bus outputs of the arbiter.
//   sel        : channel to issue (CH_I fetch, CH_D load/store)
//   inst_addr  : fetch address
//   data_addr  : load/store address
//   data_wen   : store byte enables (all zero for a load)
//   data_wdata : store data
//   addr/wen/wdata : selected bus fields (fetches never write)
module mem_req_mux
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  chan_t               sel,
    input  logic [ADDR_W-1:0]   inst_addr,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [ADDR_W-1:0]   addr,
    output logic [DATA_W/8-1:0] wen,
    output logic [DATA_W-1:0]   wdata
);

    always_comb begin
        addr  = inst_addr;
        wen   = '0;
        wdata = '0;
        if (sel == CH_D) begin
            addr  = data_addr;
            wen   = data_wen;
            wdata = data_wdata;
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Memory-side front end for the pipelined MIPS core.
// Serialises the instruction-fetch and data-access ports onto one
// variable-latency SRAM-like bus and holds the pipeline with stall until
// every request of the current pipeline cycle has completed.
//   clk, rst                      : clock, asynchronous active-low reset
//   inst_req/inst_addr/inst_rdata : fetch port; rdata registered
//   data_req/data_wen/data_addr/data_wdata/data_rdata : load/store port
//   stall                         : pipeline hold (combinational)
//   mem_req/mem_wen/mem_addr/mem_wdata : registered bus request fields
//   mem_gnt/mem_rvalid/mem_rdata  : bus accept, response/ack, read data
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int DATA_FIRST = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic [DATA_W-1:0]   inst_rdata,
    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic [DATA_W-1:0]   data_rdata,
    output logic                stall,
    output logic                mem_req,
    output logic [DATA_W/8-1:0] mem_wen,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam bit DATA_WINS = (DATA_FIRST != 0);

    arb_state_t state, state_n;
    chan_t      sel;
    logic       issue;
    logic       granted;
    logic       cap_i, cap_d;
    logic       inst_done, data_done;
    logic       inst_pend, data_pend;
    logic       wr_cur;

    logic [ADDR_W-1:0]   mux_addr;
    logic [DATA_W/8-1:0] mux_wen;
    logic [DATA_W-1:0]   mux_wdata;

    assign inst_pend = inst_req & ~inst_done;
    assign data_pend = data_req & ~data_done;
    assign stall     = inst_pend | data_pend;

    mem_req_mux #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_mux (
        .sel        (sel),
        .inst_addr  (inst_addr),
        .data_addr  (data_addr),
        .data_wen   (data_wen),
        .data_wdata (data_wdata),
        .addr       (mux_addr),
        .wen        (mux_wen),
        .wdata      (mux_wdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // When a response completes and the other channel is still pending, the
    // second access is issued straight from WAIT_* so no extra IDLE cycle is
    // spent between the two halves of a dual request.
    always_comb begin
        state_n = state;
        sel     = CH_I;
        issue   = 1'b0;
        granted = 1'b0;
        cap_i   = 1'b0;
        cap_d   = 1'b0;
        case (state)
            IDLE: begin
                if (data_pend && (DATA_WINS || !inst_pend)) begin
                    sel     = CH_D;
                    issue   = 1'b1;
                    state_n = REQ_D;
                end else if (inst_pend) begin
                    sel     = CH_I;
                    issue   = 1'b1;
                    state_n = REQ_I;
                end
            end
            REQ_I: begin
                if (mem_gnt) begin
                    granted = 1'b1;
                    state_n = WAIT_I;
                end
            end
            REQ_D: begin
                if (mem_gnt) begin
                    granted = 1'b1;
                    state_n = WAIT_D;
                end
            end
            WAIT_I: begin
                if (mem_rvalid) begin
                    cap_i = 1'b1;
                    if (data_pend) begin
                        sel     = CH_D;
                        issue   = 1'b1;
                        state_n = REQ_D;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            WAIT_D: begin
                if (mem_rvalid) begin
                    cap_d = 1'b1;
                    if (inst_pend) begin
                        sel     = CH_I;
                        issue   = 1'b1;
                        state_n = REQ_I;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Bus fields are loaded at issue and zeroed (except the address) once
    // the bus has accepted the request. wr_cur remembers whether the data
    // access in flight is a store, so its ack does not overwrite data_rdata.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_req   <= 1'b0;
            mem_addr  <= '0;
            mem_wen   <= '0;
            mem_wdata <= '0;
            wr_cur    <= 1'b0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_addr  <= mux_addr;
            mem_wen   <= mux_wen;
            mem_wdata <= mux_wdata;
            wr_cur    <= |mux_wen;
        end else if (granted) begin
            mem_req   <= 1'b0;
            mem_wen   <= '0;
            mem_wdata <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else begin
            if (cap_i) begin
                inst_rdata <= mem_rdata;
            end
            if (cap_d && !wr_cur) begin
                data_rdata <= mem_rdata;
            end
        end
    end

    // A capture can only happen while its channel is pending, i.e. while
    // stall is high, so the advance clear never races a set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else if (!stall) begin
            inst_done <= 1'b0;
            data_done <= 1'b0;
        end else begin
            if (cap_i) begin
                inst_done <= 1'b1;
            end
            if (cap_d) begin
                data_done <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Two arbiter instances run side by side: unit 0 with DATA_FIRST=1 and
// unit 1 with DATA_FIRST=0. Each has its own pipeline driver, bus agent
// and output monitor. The driver computes the expected bus order, stall
// length and read data from a word-array memory model and queues them; the
// agent and monitor pop and compare as the DUT presents bus requests and
// pipeline advances.
module tb_cpu_mem_arbiter;

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } bus_exp_t;

    typedef struct packed {
        int g;
        int r;
    } dly_t;

    typedef struct packed {
        int          stall_cyc;
        logic [31:0] ei;
        logic [31:0] ed;
    } res_t;

    logic        clk;
    logic        rst        [2];
    logic        inst_req   [2];
    logic [31:0] inst_addr  [2];
    logic [31:0] inst_rdata [2];
    logic        data_req   [2];
    logic [3:0]  data_wen   [2];
    logic [31:0] data_addr  [2];
    logic [31:0] data_wdata [2];
    logic [31:0] data_rdata [2];
    logic        stall      [2];
    logic        mem_req    [2];
    logic [3:0]  mem_wen    [2];
    logic [31:0] mem_addr   [2];
    logic [31:0] mem_wdata  [2];
    logic        mem_gnt    [2];
    logic        mem_rvalid [2];
    logic [31:0] mem_rdata  [2];
    logic        stray      [2];

    bus_exp_t bus_q [2][$];
    dly_t     dly_q [2][$];
    res_t     res_q [2][$];

    logic [31:0] agent_mem [2][16];
    logic [31:0] ref_mem   [2][16];
    logic [31:0] exp_i_cur [2];
    logic [31:0] exp_d_cur [2];

    int n_cmp;
    int n_bad;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int u, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s unit%0d: got %h expected %h", name, u, act, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] be, input logic [31:0] wd);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        end
        return r;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : gen_unit
        localparam int DF = (g == 0) ? 1 : 0;

        cpu_mem_arbiter #(
            .ADDR_W     (32),
            .DATA_W     (32),
            .DATA_FIRST (DF)
        ) dut (
            .clk        (clk),
            .rst        (rst[g]),
            .inst_req   (inst_req[g]),
            .inst_addr  (inst_addr[g]),
            .inst_rdata (inst_rdata[g]),
            .data_req   (data_req[g]),
            .data_wen   (data_wen[g]),
            .data_addr  (data_addr[g]),
            .data_wdata (data_wdata[g]),
            .data_rdata (data_rdata[g]),
            .stall      (stall[g]),
            .mem_req    (mem_req[g]),
            .mem_wen    (mem_wen[g]),
            .mem_addr   (mem_addr[g]),
            .mem_wdata  (mem_wdata[g]),
            .mem_gnt    (mem_gnt[g]),
            .mem_rvalid (mem_rvalid[g]),
            .mem_rdata  (mem_rdata[g])
        );

        assert property (@(posedge clk) disable iff (!rst[g])
            stall[g] |=> $stable({inst_req[g], inst_addr[g], data_req[g],
                                  data_wen[g], data_addr[g], data_wdata[g]}))
            else $error("pipeline inputs changed while stalled, unit %0d", g);

        // Pipeline-advance monitor: counts stall cycles of the current step
        // and checks them plus both read registers when stall drops.
        initial begin : monitor
            int   cnt;
            res_t e;
            cnt = 0;
            forever begin
                @(negedge clk);
                if (!rst[g]) begin
                    cnt = 0;
                end else if (inst_req[g] || data_req[g]) begin
                    if (stall[g]) begin
                        cnt++;
                    end else begin
                        if (res_q[g].size() == 0) begin
                            n_cmp++;
                            n_bad++;
                            $display("FAIL advance unit%0d: got advance expected none", g);
                        end else begin
                            e = res_q[g].pop_front();
                            check("stall_cycles", g, cnt, e.stall_cyc);
                            check("inst_rdata", g, inst_rdata[g], e.ei);
                            check("data_rdata", g, data_rdata[g], e.ed);
                        end
                        cnt = 0;
                    end
                end else begin
                    check("stall_idle", g, 32'(stall[g]), 32'h0);
                end
            end
        end

        // Bus agent: grants and responds with the delays queued by the
        // driver, checks request fields, and injects stray rvalids while the
        // arbiter is idle or still waiting for a grant.
        initial begin : agent
            dly_t     d;
            bus_exp_t cur;
            bus_exp_t e;
            bit       abort;
            mem_gnt[g]    = 1'b0;
            mem_rvalid[g] = 1'b0;
            mem_rdata[g]  = 32'h0;
            @(negedge clk);
            forever begin
                mem_gnt[g]    = 1'b0;
                mem_rvalid[g] = 1'b0;
                if (rst[g] && mem_req[g]) begin
                    cur.addr  = mem_addr[g];
                    cur.wen   = mem_wen[g];
                    cur.wdata = mem_wdata[g];
                    if (bus_q[g].size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL bus_request unit%0d: got addr %h expected no request", g, cur.addr);
                        e = cur;
                    end else begin
                        e = bus_q[g].pop_front();
                    end
                    check("bus_addr", g, cur.addr, e.addr);
                    check("bus_wen", g, 32'(cur.wen), 32'(e.wen));
                    check("bus_wdata", g, cur.wdata, e.wdata);
                    if (dly_q[g].size() != 0) d = dly_q[g].pop_front();
                    else begin d.g = 0; d.r = 0; end
                    abort = 1'b0;
                    for (int k = 0; k < d.g; k++) begin
                        mem_rvalid[g] = ($urandom_range(0, 2) == 0);
                        mem_rdata[g]  = $urandom();
                        @(negedge clk);
                        mem_rvalid[g] = 1'b0;
                        if (!rst[g]) begin
                            abort = 1'b1;
                            break;
                        end
                        check("bus_hold_req", g, 32'(mem_req[g]), 32'h1);
                        check("bus_hold_addr", g, mem_addr[g], cur.addr);
                        check("bus_hold_wen", g, 32'(mem_wen[g]), 32'(cur.wen));
                        check("bus_hold_wdata", g, mem_wdata[g], cur.wdata);
                    end
                    if (!abort) begin
                        mem_gnt[g] = 1'b1;
                        if (cur.wen != 4'h0) begin
                            agent_mem[g][cur.addr[5:2]] = merge(agent_mem[g][cur.addr[5:2]], cur.wen, cur.wdata);
                        end
                        @(negedge clk);
                        mem_gnt[g] = 1'b0;
                        if (!rst[g]) begin
                            abort = 1'b1;
                        end else begin
                            check("wait_req", g, 32'(mem_req[g]), 32'h0);
                            check("wait_wen", g, 32'(mem_wen[g]), 32'h0);
                            check("wait_wdata", g, mem_wdata[g], 32'h0);
                        end
                    end
                    if (!abort) begin
                        for (int k = 0; k < d.r; k++) begin
                            @(negedge clk);
                            if (!rst[g]) begin
                                abort = 1'b1;
                                break;
                            end
                        end
                    end
                    if (!abort) begin
                        mem_rvalid[g] = 1'b1;
                        mem_rdata[g]  = (cur.wen != 4'h0) ? $urandom() : agent_mem[g][cur.addr[5:2]];
                        @(negedge clk);
                    end
                end else begin
                    if (stray[g]) begin
                        mem_rvalid[g] = 1'b1;
                        mem_rdata[g]  = 32'hDEADBEEF;
                        stray[g]      = 1'b0;
                    end else if (rst[g]) begin
                        mem_rvalid[g] = ($urandom_range(0, 5) == 0);
                        mem_rdata[g]  = $urandom();
                    end
                    @(negedge clk);
                end
            end
        end
    end

    // One pipeline step: queue expectations, drive the requests, hold them
    // until stall drops, and return just after the advance edge. Unit 0
    // serves data first on a dual request, unit 1 fetch first.
    task automatic do_step(input int u, input bit ir, input logic [31:0] ia,
                           input bit dr, input logic [3:0] dw, input logic [31:0] da,
                           input logic [31:0] dd, input int g0, input int r0,
                           input int g1, input int r1);
        bit       seq_d [2];
        int       na;
        int       tot;
        int       n;
        res_t     e;
        bus_exp_t b;
        dly_t     d;
        na  = 0;
        tot = 0;
        if (ir && dr) begin
            seq_d[0] = (u == 0);
            seq_d[1] = (u != 0);
            na = 2;
        end else if (ir) begin
            seq_d[0] = 1'b0;
            na = 1;
        end else if (dr) begin
            seq_d[0] = 1'b1;
            na = 1;
        end
        for (int k = 0; k < na; k++) begin
            d.g = (k == 0) ? g0 : g1;
            d.r = (k == 0) ? r0 : r1;
            dly_q[u].push_back(d);
            tot += 2 + d.g + d.r;
            if (seq_d[k]) begin
                b.addr  = da;
                b.wen   = dw;
                b.wdata = dd;
                if (dw == 4'h0) exp_d_cur[u] = ref_mem[u][da[5:2]];
                else ref_mem[u][da[5:2]] = merge(ref_mem[u][da[5:2]], dw, dd);
            end else begin
                b.addr  = ia;
                b.wen   = 4'h0;
                b.wdata = 32'h0;
                exp_i_cur[u] = ref_mem[u][ia[5:2]];
            end
            bus_q[u].push_back(b);
        end
        e.stall_cyc = 1 + tot;
        e.ei        = exp_i_cur[u];
        e.ed        = exp_d_cur[u];
        if (na != 0) res_q[u].push_back(e);
        inst_req[u]   = ir;
        inst_addr[u]  = ia;
        data_req[u]   = dr;
        data_wen[u]   = dw;
        data_addr[u]  = da;
        data_wdata[u] = dd;
        n = 0;
        forever begin
            @(negedge clk);
            if (!stall[u]) break;
            n++;
            if (n > 400) begin
                n_bad++;
                $display("FAIL stall_timeout unit%0d: got stall after %0d cycles expected release", u, n);
                $fatal(1, "stall never released");
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom() & 32'hFFFF_FFC0) | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic run_unit(input int u);
        bus_exp_t b;
        dly_t     d;
        int       gap;
        int       kind;
        // Reset while a load waits for its response.
        b.addr = 32'h0000_0040; b.wen = 4'h0; b.wdata = 32'h0;
        bus_q[u].push_back(b);
        d.g = 0; d.r = 30;
        dly_q[u].push_back(d);
        data_req[u]  = 1'b1;
        data_addr[u] = 32'h0000_0040;
        repeat (3) @(negedge clk);
        #2;
        rst[u]       = 1'b0;
        data_req[u]  = 1'b0;
        data_addr[u] = 32'h0;
        #1;
        check("rst_mem_req", u, 32'(mem_req[u]), 32'h0);
        check("rst_mem_addr", u, mem_addr[u], 32'h0);
        check("rst_mem_wen", u, 32'(mem_wen[u]), 32'h0);
        check("rst_mem_wdata", u, mem_wdata[u], 32'h0);
        check("rst_inst_rdata", u, inst_rdata[u], 32'h0);
        check("rst_data_rdata", u, data_rdata[u], 32'h0);
        check("rst_stall", u, 32'(stall[u]), 32'h0);
        repeat (2) @(negedge clk);
        rst[u]   = 1'b1;
        stray[u] = 1'b1;
        repeat (3) @(negedge clk);
        check("stray_data_rdata", u, data_rdata[u], 32'h0);
        check("stray_inst_rdata", u, inst_rdata[u], 32'h0);
        @(posedge clk);
        #1;
        // Fetch only, single-cycle grant and response.
        do_step(u, 1'b1, 32'hBFC00000, 1'b0, 4'h0, 32'h0, 32'h0, 0, 0, 0, 0);
        // Simultaneous load and fetch.
        do_step(u, 1'b1, 32'hBFC00004, 1'b1, 4'h0, 32'h0000_0088, 32'h0, 0, 0, 0, 0);
        // Store with grant held off for three cycles.
        do_step(u, 1'b0, 32'h0, 1'b1, 4'b0011, 32'h0000_0090, 32'h12345678, 3, 0, 0, 0);
        // Back-to-back loads, the second one reading the stored word.
        do_step(u, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_008C, 32'h0, 0, 0, 0, 0);
        do_step(u, 1'b0, 32'h0, 1'b1, 4'h0, 32'h0000_0090, 32'h0, 0, 1, 0, 0);
        // Randomised traffic with idle gaps.
        for (int s = 0; s < 120; s++) begin
            kind = $urandom_range(0, 2);
            do_step(u, (kind != 1), rand_addr(), (kind != 0),
                    ($urandom_range(0, 1) != 0) ? 4'($urandom()) : 4'h0,
                    rand_addr(), $urandom(),
                    $urandom_range(0, 3), $urandom_range(0, 3),
                    $urandom_range(0, 3), $urandom_range(0, 3));
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                inst_req[u] = 1'b0;
                data_req[u] = 1'b0;
                repeat (gap) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        inst_req[u] = 1'b0;
        data_req[u] = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin : main
        logic [31:0] v;
        n_cmp = 0;
        n_bad = 0;
        for (int u = 0; u < 2; u++) begin
            rst[u]        = 1'b0;
            inst_req[u]   = 1'b0;
            inst_addr[u]  = 32'h0;
            data_req[u]   = 1'b0;
            data_wen[u]   = 4'h0;
            data_addr[u]  = 32'h0;
            data_wdata[u] = 32'h0;
            stray[u]      = 1'b0;
            exp_i_cur[u]  = 32'h0;
            exp_d_cur[u]  = 32'h0;
            for (int i = 0; i < 16; i++) begin
                v = $urandom();
                agent_mem[u][i] = v;
                ref_mem[u][i]   = v;
            end
            agent_mem[u][0] = 32'h24080001;
            ref_mem[u][0]   = 32'h24080001;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("init_mem_req", u, 32'(mem_req[u]), 32'h0);
            check("init_mem_addr", u, mem_addr[u], 32'h0);
            check("init_inst_rdata", u, inst_rdata[u], 32'h0);
            check("init_data_rdata", u, data_rdata[u], 32'h0);
            check("init_stall", u, 32'(stall[u]), 32'h0);
            rst[u] = 1'b1;
        end
        @(posedge clk);
        #1;
        fork
            run_unit(0);
            run_unit(1);
        join
        repeat (5) @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            check("left_bus_q", u, 32'(bus_q[u].size()), 32'h0);
            check("left_dly_q", u, 32'(dly_q[u].size()), 32'h0);
            check("left_res_q", u, 32'(res_q[u].size()), 32'h0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
